layer_argmax: RTL and testbench

- Downstream consumer of a fully-connected layer built from nodeN_M neurons, each emitting a registered, ReLU-clamped IEEE-754 single (N0x..N{NUM_NODES-1}x).
- On a start pulse, snapshots all node outputs and scans them sequentially, one per cycle.
- Reports the index and value of the largest activation, which is the network's class decision.
- Feeds the classification result/status logic.

---
 rtl/layer_pkg.sv | 21 ++
 rtl/layer_argmax_fp_pos_gt.sv | 18 +
 rtl/layer_argmax.sv | 95 +++++++++
 tb/tb_layer_argmax.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared types and constants for the post-layer argmax block.
// Holds the float format constants, FSM state encoding and the magnitude helper.
package layer_pkg;

    localparam int          FP_W          = 32;
    localparam logic [31:0] FP_ZERO       = 32'd0;
    localparam int          FP_SIGN_BIT   = 31;
    localparam int          DEF_NUM_NODES = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Negative activations collapse to +0; non-negative floats order exactly by [30:0].
    function automatic logic [FP_W-2:0] fp_mag(input logic [FP_W-1:0] v);
        return v[FP_SIGN_BIT] ? {(FP_W-1){1'b0}} : v[FP_W-2:0];
    endfunction

endpackage

// File: rtl/layer_argmax_fp_pos_gt.sv
// Combinational strict a > b on sanitised (sign-cleared) IEEE-754 singles.
// NaN patterns are ordered by magnitude like any other value.
module fp_pos_gt
    import layer_pkg::*;
(
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic            o_gt
);

    logic [FP_W-2:0] w_a_mag;
    logic [FP_W-2:0] w_b_mag;

    assign w_a_mag = fp_mag(i_a);
    assign w_b_mag = fp_mag(i_b);
    assign o_gt    = (w_a_mag > w_b_mag);

endmodule

// File: rtl/layer_argmax.sv
// Snapshots the node outputs on start and scans one node per cycle,
// reporting the index and value of the largest activation.
module layer_argmax
    import layer_pkg::*;
#(
    parameter int NUM_NODES = DEF_NUM_NODES,
    parameter int IDX_W     = 4
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [FP_W*NUM_NODES-1:0] node_bus,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          class_idx,
    output logic [FP_W-1:0]           class_val
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    state_t            r_state;
    logic [FP_W-1:0]   r_snap [NUM_NODES];
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_best_idx;
    logic [FP_W-1:0]   r_best_val;

    logic [FP_W-1:0]   w_cur;
    logic              w_gt;

    assign w_cur = r_snap[r_cnt];

    fp_pos_gt u_gt (
        .i_a  (w_cur),
        .i_b  (r_best_val),
        .o_gt (w_gt)
    );

    // Scan FSM: capture, sequential compare, publish result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_best_idx <= '0;
            r_best_val <= FP_ZERO;
            busy       <= 1'b0;
            done       <= 1'b0;
            class_idx  <= '0;
            class_val  <= FP_ZERO;
            for (int i = 0; i < NUM_NODES; i++) begin
                r_snap[i] <= FP_ZERO;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < NUM_NODES; i++) begin
                            r_snap[i] <= node_bus[FP_W*i +: FP_W];
                        end
                        r_cnt      <= '0;
                        r_best_idx <= '0;
                        r_best_val <= FP_ZERO;
                        busy       <= 1'b1;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_gt) begin
                        r_best_idx <= r_cnt;
                        r_best_val <= w_cur;
                    end
                    r_cnt <= r_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
                    // Publish on the last compare, folding in its own result.
                    if (r_cnt == LAST_IDX) begin
                        class_idx <= w_gt ? r_cnt : r_best_idx;
                        class_val <= w_gt ? w_cur : r_best_val;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_argmax.sv
// Randomised and directed bench for layer_argmax against a plain argmax model.
module tb_layer_argmax;

    localparam int NUM = 15;
    localparam int IW  = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [32*NUM-1:0] node_bus;
    logic              busy;
    logic              done;
    logic [IW-1:0]     class_idx;
    logic [31:0]       class_val;

    logic [31:0] nodes [NUM];
    int n_checks;
    int n_errors;

    layer_argmax #(.NUM_NODES(NUM), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .node_bus  (node_bus),
        .busy      (busy),
        .done      (done),
        .class_idx (class_idx),
        .class_val (class_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: negative values count as zero, first strictly-larger value wins.
    task automatic model(output logic [31:0] e_idx, output logic [31:0] e_val);
        longint unsigned best;
        longint unsigned m;
        best  = 0;
        e_idx = 32'd0;
        e_val = 32'd0;
        for (int i = 0; i < NUM; i++) begin
            m = nodes[i][31] ? 0 : longint'(nodes[i] & 32'h7FFF_FFFF);
            if (m > best) begin
                best  = m;
                e_idx = i;
                e_val = nodes[i];
            end
        end
    endtask

    task automatic pack_bus();
        for (int i = 0; i < NUM; i++) node_bus[32*i +: 32] = nodes[i];
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < NUM; i++) nodes[i] = v;
    endtask

    task automatic run_scan(input string tag, input bit second_start);
        logic [31:0] e_idx;
        logic [31:0] e_val;
        int busy_cnt;
        int done_at;
        int pulses;
        pack_bus();
        model(e_idx, e_val);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_at  = -1;
        pulses   = 0;
        for (int e = 1; e <= NUM + 6; e++) begin
            if (second_start && e == 4) begin
                start    = 1'b1;
                node_bus = {NUM{32'h3F80_0000}};
            end
            @(posedge clk);
            #1;
            if (second_start && e == 4) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = e;
                    check_eq({tag, " idx"}, 32'(class_idx), e_idx);
                    check_eq({tag, " val"}, class_val, e_val);
                end
            end
        end
        check_eq({tag, " latency"}, done_at, NUM);
        check_eq({tag, " busy_cycles"}, busy_cnt, NUM);
        check_eq({tag, " done_pulses"}, pulses, 1);
        check_eq({tag, " hold_idx"}, 32'(class_idx), e_idx);
        check_eq({tag, " hold_val"}, class_val, e_val);
    endtask

    function automatic logic [31:0] rand_node(input int i);
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 7))
            0, 1: r = 32'd0;
            2:    r[31] = 1'b1;
            3:    r = (i > 0) ? nodes[$urandom_range(0, i - 1)] : 32'd0;
            4:    r = r & 32'h0000_00FF;
            default: r[31] = 1'b0;
        endcase
        return r;
    endfunction

    initial begin
        int pulses;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start    = 1'b0;
        node_bus = '0;
        fill(32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst idx", 32'(class_idx), 32'd0);
        check_eq("rst val", class_val, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        fill(32'd0);
        nodes[0] = 32'h3F00_0000; nodes[1] = 32'h4000_0000; nodes[2] = 32'h3F80_0000;
        run_scan("basic", 1'b0);

        fill(32'h3F00_0000);
        nodes[14] = 32'h3F80_0000;
        run_scan("last", 1'b0);

        fill(32'd0);
        nodes[3] = 32'h4000_0000; nodes[9] = 32'h4000_0000;
        run_scan("tie", 1'b0);

        fill(32'd0);
        nodes[0] = 32'hBF80_0000;
        run_scan("neg", 1'b0);

        fill(32'd0);
        nodes[5] = 32'h0000_0001;
        run_scan("denorm", 1'b0);

        fill(32'd0);
        nodes[7] = 32'h4040_0000; nodes[2] = 32'h3F00_0000;
        run_scan("restart", 1'b1);

        // Asynchronous reset during the scan.
        for (int i = 0; i < NUM; i++) nodes[i] = rand_node(i);
        nodes[4] = 32'h4100_0000;
        pack_bus();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst busy", 32'(busy), 32'd0);
        check_eq("arst done", 32'(done), 32'd0);
        check_eq("arst idx", 32'(class_idx), 32'd0);
        check_eq("arst val", class_val, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int e = 0; e < NUM + 5; e++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check_eq("arst no_done", pulses, 0);
        run_scan("post_rst", 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NUM; i++) nodes[i] = rand_node(i);
            run_scan($sformatf("rand%0d", t), (t % 5) == 4);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
